// File: rtl/fir_uart_packer.sv
// Drains FIR output FIFO samples and serialises each as a UART frame: sync, data MSB first, XOR checksum.
// Raises o_sig_comp after SAMPLE_COUNT frames; byte pacing follows i_tx_busy, FIFO pacing follows i_fifo_empty.
module fir_uart_packer #(
  parameter int         DATA_WIDTH   = 32,
  parameter int         SAMPLE_COUNT = 1024,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_start,
  input  logic                  i_fifo_empty,
  output logic                  o_fifo_rden,
  input  logic [DATA_WIDTH-1:0] i_fifo_dataout,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_start,
  input  logic                  i_tx_busy,
  output logic                  o_sig_comp,
  output logic                  o_busy
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = $clog2(NB + 2);
  localparam int CW = $clog2(SAMPLE_COUNT + 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_DATA, READ, LATCH, SEND, GUARD, WAIT_TX, DONE
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [7:0]            chk_q, chk_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_start_q, rden_q, sig_comp_q, busy_q;

  function automatic logic [7:0] xor_bytes(input logic [DATA_WIDTH-1:0] d);
    logic [7:0] acc;
    acc = 8'h00;
    for (int b = 0; b < NB; b++) acc ^= d[8*b +: 8];
    return acc;
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    chk_d     = chk_q;
    tx_data_d = tx_data_q;
    case (state_q)
      IDLE: if (i_start) begin
        cnt_d   = '0;
        state_d = WAIT_DATA;
      end
      WAIT_DATA: if (!i_fifo_empty) state_d = READ;
      READ:      state_d = LATCH;
      LATCH: begin
        shreg_d = i_fifo_dataout;
        chk_d   = xor_bytes(i_fifo_dataout);
        idx_d   = '0;
        state_d = SEND;
      end
      SEND: begin
        // Data bytes leave from the top of the shift register, MSB first.
        if (idx_q == '0) begin
          tx_data_d = SYNC_BYTE;
        end else if (idx_q == IW'(NB + 1)) begin
          tx_data_d = chk_q;
        end else begin
          tx_data_d = shreg_q[DATA_WIDTH-1 -: 8];
          shreg_d   = shreg_q << 8;
        end
        state_d = GUARD;
      end
      GUARD: state_d = WAIT_TX;
      WAIT_TX: if (!i_tx_busy) begin
        if (idx_q < IW'(NB + 1)) begin
          idx_d   = idx_q + IW'(1);
          state_d = SEND;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = (cnt_d == CW'(SAMPLE_COUNT)) ? DONE : WAIT_DATA;
        end
      end
      DONE: if (i_start) begin
        cnt_d   = '0;
        state_d = WAIT_DATA;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so strobes coincide with their state.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shreg_q    <= '0;
      chk_q      <= 8'h00;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      rden_q     <= 1'b0;
      sig_comp_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shreg_q    <= shreg_d;
      chk_q      <= chk_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= (state_d == GUARD);
      rden_q     <= (state_d == READ);
      sig_comp_q <= (state_d == DONE);
      busy_q     <= (state_d != IDLE) && (state_d != DONE);
    end
  end

  assign o_tx_data   = tx_data_q;
  assign o_tx_start  = tx_start_q;
  assign o_fifo_rden = rden_q;
  assign o_sig_comp  = sig_comp_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_fir_uart_packer.sv
// Scoreboard bench for fir_uart_packer: FIFO and UART models, expected frame bytes queued per pushed sample.
module tb_fir_uart_packer;

  localparam int DW       = 32;
  localparam int SC       = 3;
  localparam int BUSY_CYC = 10;

  logic          i_clk = 1'b0;
  logic          i_rstn = 1'b0;
  logic          i_start = 1'b0;
  logic          i_fifo_empty = 1'b1;
  logic          o_fifo_rden;
  logic [DW-1:0] i_fifo_dataout = '0;
  logic [7:0]    o_tx_data;
  logic          o_tx_start;
  logic          i_tx_busy = 1'b0;
  logic          o_sig_comp;
  logic          o_busy;

  fir_uart_packer #(.DATA_WIDTH(DW), .SAMPLE_COUNT(SC), .SYNC_BYTE(8'hA5)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start), .i_fifo_empty(i_fifo_empty),
    .o_fifo_rden(o_fifo_rden), .i_fifo_dataout(i_fifo_dataout), .o_tx_data(o_tx_data),
    .o_tx_start(o_tx_start), .i_tx_busy(i_tx_busy), .o_sig_comp(o_sig_comp), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rden_count = 0;
  int tx_count = 0;
  int first_tx_cyc = -1;
  int frame_pos = 0;
  int busy_cnt = 0;
  logic hold_busy = 1'b0;
  logic [7:0] exp_q[$];
  logic [DW-1:0] fifo_q[$];

  always @(posedge i_clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference frame: sync, bytes most significant first, XOR of data bytes.
  task automatic push_sample(input logic [DW-1:0] s);
    logic [7:0] b;
    logic [7:0] x;
    x = 8'h00;
    exp_q.push_back(8'hA5);
    for (int i = DW / 8 - 1; i >= 0; i--) begin
      b = 8'((s >> (8 * i)) & 255);
      x = x ^ b;
      exp_q.push_back(b);
    end
    exp_q.push_back(x);
    fifo_q.push_back(s);
    i_fifo_empty = 1'b0;
  endtask

  // FIFO read model, UART busy model, and output monitor.
  always @(negedge i_clk) begin
    if (o_fifo_rden) begin
      rden_count++;
      if (i_fifo_empty || fifo_q.size() == 0) begin
        total++; bad++;
        $display("FAIL rden_while_empty actual=1 required=0 (t=%0t)", $time);
      end else begin
        i_fifo_dataout = fifo_q.pop_front();
      end
    end
    i_fifo_empty = (fifo_q.size() == 0);
    if (o_tx_start) begin
      tx_count++;
      if (first_tx_cyc < 0) first_tx_cyc = cyc;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_tx actual=%0h required=none (t=%0t)", o_tx_data, $time);
      end else begin
        chk("tx_byte", 64'(o_tx_data), 64'(exp_q.pop_front()));
      end
      frame_pos = (frame_pos + 1) % 6;
      busy_cnt = BUSY_CYC;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    i_tx_busy = hold_busy || (busy_cnt > 0);
  end

  task automatic pulse_start();
    @(negedge i_clk); i_start = 1'b1;
    @(negedge i_clk); i_start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge i_clk);
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    for (int i = 0; i < 100 && i_tx_busy; i++) @(negedge i_clk);
    repeat (3) @(negedge i_clk);
  endtask

  task automatic wait_pos(input int p);
    int k;
    k = 0;
    while (frame_pos != p && k < 500) begin @(negedge i_clk); k++; end
    chk("wait_pos_timeout", 64'(frame_pos), 64'(p));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rden"},  64'(o_fifo_rden), 64'd0);
    chk({tag, "_start"}, 64'(o_tx_start), 64'd0);
    chk({tag, "_data"},  64'(o_tx_data), 64'd0);
    chk({tag, "_comp"},  64'(o_sig_comp), 64'd0);
    chk({tag, "_busy"},  64'(o_busy), 64'd0);
  endtask

  initial begin
    int t0;
    int base_rden;
    int base_tx;
    logic [7:0] held;
    logic stable;

    repeat (3) @(negedge i_clk);
    chk_reset_outputs("reset");
    i_rstn = 1'b1;
    repeat (2) @(negedge i_clk);

    // Single frame with first-byte latency.
    pulse_start();
    t0 = cyc;
    push_sample(32'h12345678);
    drain();
    chk("first_tx_latency", 64'(first_tx_cyc - t0), 64'd4);
    chk("single_rden", 64'(rden_count), 64'd1);
    chk("single_txcount", 64'(tx_count), 64'd6);

    // Negative sample.
    push_sample(32'hFFFFFF9C);
    drain();
    chk("neg_sigcomp", 64'(o_sig_comp), 64'd0);

    // Run completion with two samples left over.
    push_sample($urandom());
    push_sample($urandom());
    push_sample($urandom());
    for (int i = 0; i < 3000 && !o_sig_comp; i++) @(negedge i_clk);
    chk("done_sigcomp", 64'(o_sig_comp), 64'd1);
    chk("done_busy", 64'(o_busy), 64'd0);
    chk("done_fifo_left", 64'(fifo_q.size()), 64'd2);
    chk("done_rden", 64'(rden_count), 64'd3);
    chk("done_exp_left", 64'(exp_q.size()), 64'd12);
    repeat (30) @(negedge i_clk);
    chk("done_no_reads", 64'(rden_count), 64'd3);
    chk("done_no_tx", 64'(tx_count), 64'd18);
    pulse_start();
    chk("restart_sigcomp", 64'(o_sig_comp), 64'd0);
    drain();
    chk("restart_rden", 64'(rden_count), 64'd5);
    chk("restart_sigcomp_mid", 64'(o_sig_comp), 64'd0);

    // FIFO underflow hold.
    base_rden = rden_count;
    base_tx = tx_count;
    repeat (50) @(negedge i_clk);
    chk("empty_hold_rden", 64'(rden_count - base_rden), 64'd0);
    chk("empty_hold_tx", 64'(tx_count - base_tx), 64'd0);
    chk("empty_hold_busy", 64'(o_busy), 64'd1);

    // UART backpressure hold after the sync byte.
    push_sample($urandom());
    wait_pos(1);
    hold_busy = 1'b1;
    i_tx_busy = 1'b1;
    held = o_tx_data;
    base_tx = tx_count;
    stable = 1'b1;
    repeat (200) begin
      @(negedge i_clk);
      if (o_tx_data !== held) stable = 1'b0;
    end
    chk("busy_hold_stable", 64'(stable), 64'd1);
    chk("busy_hold_data", 64'(held), 64'hA5);
    chk("busy_hold_tx", 64'(tx_count - base_tx), 64'd0);
    hold_busy = 1'b0;
    drain();
    chk("run2_sigcomp", 64'(o_sig_comp), 64'd1);

    // Start pulse mid-frame must not restart the count.
    pulse_start();
    push_sample($urandom());
    drain();
    push_sample($urandom());
    wait_pos(2);
    pulse_start();
    drain();
    chk("start_busy_sigcomp_early", 64'(o_sig_comp), 64'd0);
    push_sample($urandom());
    drain();
    chk("start_busy_sigcomp", 64'(o_sig_comp), 64'd1);

    // Reset after the third byte of a frame.
    pulse_start();
    push_sample($urandom());
    wait_pos(3);
    i_rstn = 1'b0;
    @(negedge i_clk);
    chk_reset_outputs("midreset");
    i_rstn = 1'b1;
    while (frame_pos != 0) begin
      void'(exp_q.pop_front());
      frame_pos = (frame_pos + 1) % 6;
    end
    base_tx = tx_count;
    repeat (100) @(negedge i_clk);
    chk("midreset_no_tx", 64'(tx_count - base_tx), 64'd0);
    chk("midreset_idle_busy", 64'(o_busy), 64'd0);

    pulse_start();
    push_sample($urandom());
    drain();
    chk("post_reset_tx", 64'(tx_count - base_tx), 64'd6);
    chk("post_reset_sigcomp", 64'(o_sig_comp), 64'd0);
    chk("post_reset_busy", 64'(o_busy), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
